// File: rtl/bidir_bus_hub.sv
// Host-bus front end: terminates the DSP tri-state bus and fans it out to NCH read channels.
// Optional bus-collision counter is enabled with `define BUS_COLLISION_CNT_EN.
module bidir_bus_hub #(
   parameter int          DW           = 16,
   parameter int          AW           = 8,
   parameter int          NCH          = 8,
   parameter int          WE_DLY       = 2,
   parameter logic [15:0] IDLE_PATTERN = 16'h3333,
   parameter int          AB_OFFSET    = 0,
   parameter int          STAT_ADDR    = 'hFF
) (
   input  logic              xclk,
   input  logic              reset,
   inout  wire  [DW-1:0]     db,
   input  logic              cs,
   input  logic              re,
   input  logic              we,
   input  logic [AW-1:0]     ab,
   output logic [DW-1:0]     db_in,
   output logic              write_qualified,
   output logic              write_strobe,
   output logic              read_qualified,
   output logic              read_strobe,
   input  logic [NCH*DW-1:0] ch_data,
   input  logic [NCH-1:0]    ch_avail,
   output logic              rw_conflict
);

   localparam logic [DW-1:0] IDLE_DW = DW'(IDLE_PATTERN);

   logic [WE_DLY-1:0] we_del;
   logic              wq_prev;
   logic              rq_prev;
   logic              oe_reg;
   logic [DW-1:0]     rd_data_reg;
   logic [DW-1:0]     rd_sel;

`ifdef BUS_COLLISION_CNT_EN
   localparam logic [AW-1:0] STAT_AB = AW'(STAT_ADDR + AB_OFFSET);

   logic [15:0] coll_cnt;
   logic        multi_avail;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign multi_avail = (ch_avail & (ch_avail - NCH'(1))) != '0;

   always_ff @(posedge xclk or negedge reset) begin
      if (!reset)
         coll_cnt <= '0;
      else if (write_strobe && (ab == STAT_AB))
         coll_cnt <= '0;
      else if (read_qualified && multi_avail)
         coll_cnt <= sat_inc(coll_cnt);
   end
`else
   localparam int stat_addr_unused = STAT_ADDR + AB_OFFSET;
   logic ab_unused;
   assign ab_unused = ^ab;
`endif

   // Write settle: the MSB of we_del clears only after WE_DLY consecutive low-we edges
   always_ff @(posedge xclk or negedge reset) begin
      if (!reset)
         we_del <= '1;
      else if (we)
         we_del <= '1;
      else
         we_del <= we_del << 1;
   end

   assign write_qualified = !we_del[WE_DLY-1] && !cs;
   assign read_qualified  = !re && !cs;

   // Edge detectors come out of reset armed-high so an access held across reset does not strobe
   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         wq_prev      <= 1'b1;
         rq_prev      <= 1'b1;
         write_strobe <= 1'b0;
         read_strobe  <= 1'b0;
         rw_conflict  <= 1'b0;
      end else begin
         wq_prev      <= write_qualified;
         rq_prev      <= read_qualified;
         write_strobe <= write_qualified && !wq_prev;
         read_strobe  <= read_qualified && !rq_prev;
         if (!re && !we && !cs)
            rw_conflict <= 1'b1;
      end
   end

   // Channel 0 wins: scan from the top so lower indices overwrite
   always_comb begin
      rd_sel = IDLE_DW;
      for (int i = NCH-1; i >= 0; i--) begin
         if (ch_avail[i])
            rd_sel = ch_data[i*DW +: DW];
      end
`ifdef BUS_COLLISION_CNT_EN
      if (ab == STAT_AB)
         rd_sel = DW'(coll_cnt);
`endif
   end

   always_ff @(posedge xclk or negedge reset) begin
      if (!reset) begin
         oe_reg      <= 1'b0;
         rd_data_reg <= '0;
      end else begin
         oe_reg <= read_qualified;
         if (read_qualified)
            rd_data_reg <= rd_sel;
      end
   end

   assign db    = oe_reg ? rd_data_reg : {DW{1'bz}};
   assign db_in = db;

endmodule

// File: tb/tb_bidir_bus_hub.sv
// Bench for bidir_bus_hub: directed bus accesses plus random transactions against a reference model.
module tb_bidir_bus_hub;
   localparam int DW = 16;
   localparam int NCH = 8;
   localparam int WE_DLY = 2;

   logic xclk = 1'b0;
   always #5 xclk = ~xclk;

   logic reset;
   logic cs, re, we;
   logic [7:0] ab;
   logic [NCH*DW-1:0] ch_data;
   logic [NCH-1:0] ch_avail;
   tri1  [DW-1:0] db;
   logic tb_oe;
   logic [DW-1:0] tb_val;
   logic [DW-1:0] db_in;
   logic write_qualified, write_strobe, read_qualified, read_strobe, rw_conflict;

   assign db = tb_oe ? tb_val : 'z;

   bidir_bus_hub dut (
      .xclk(xclk), .reset(reset), .db(db), .cs(cs), .re(re), .we(we), .ab(ab),
      .db_in(db_in), .write_qualified(write_qualified), .write_strobe(write_strobe),
      .read_qualified(read_qualified), .read_strobe(read_strobe),
      .ch_data(ch_data), .ch_avail(ch_avail), .rw_conflict(rw_conflict)
   );

   logic cs_b, re_b, we_b;
   logic [7:0] ab_b;
   logic [23:0] ch_data_b;
   logic [2:0] ch_avail_b;
   tri1  [7:0] db_b;
   logic tb_oe_b;
   logic [7:0] tb_val_b;
   logic [7:0] db_in_b;
   logic wq_b, ws_b, rq_b, rs_b, conf_b;

   assign db_b = tb_oe_b ? tb_val_b : 'z;

   bidir_bus_hub #(.DW(8), .NCH(3), .WE_DLY(3)) dut_b (
      .xclk(xclk), .reset(reset), .db(db_b), .cs(cs_b), .re(re_b), .we(we_b), .ab(ab_b),
      .db_in(db_in_b), .write_qualified(wq_b), .write_strobe(ws_b),
      .read_qualified(rq_b), .read_strobe(rs_b),
      .ch_data(ch_data_b), .ch_avail(ch_avail_b), .rw_conflict(conf_b)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state, expressed in access-level terms
   int          m_wlow;
   bit          m_wq_prev, m_rq_prev, m_ws, m_rs, m_oe, m_conf;
   logic [15:0] m_rd, m_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] ref_pick(input logic [15:0] cnt);
`ifdef BUS_COLLISION_CNT_EN
      if (ab == 8'hFF) return cnt;
`endif
      for (int i = 0; i < NCH; i++)
         if (ch_avail[i]) return ch_data[i*DW +: DW];
      return 16'h3333;
   endfunction

   task automatic check_all();
      logic [15:0] exp_db;
      exp_db = m_oe ? m_rd : (tb_oe ? tb_val : 16'hFFFF);
      chk("db", 32'(db), 32'(exp_db));
      chk("db_in", 32'(db_in), 32'(exp_db));
      chk("write_qualified", 32'(write_qualified), 32'((m_wlow >= WE_DLY) && !cs));
      chk("write_strobe", 32'(write_strobe), 32'(m_ws));
      chk("read_qualified", 32'(read_qualified), 32'(!re && !cs));
      chk("read_strobe", 32'(read_strobe), 32'(m_rs));
      chk("rw_conflict", 32'(rw_conflict), 32'(m_conf));
   endtask

   task automatic model_reset();
      m_wlow = 0; m_wq_prev = 1'b1; m_rq_prev = 1'b1;
      m_ws = 1'b0; m_rs = 1'b0; m_oe = 1'b0; m_conf = 1'b0;
      m_rd = '0; m_cnt = '0;
   endtask

   task automatic step();
      bit wq_pre, rq_pre, ws_old;
      logic [15:0] cnt_old;
      wq_pre  = (m_wlow >= WE_DLY) && !cs;
      rq_pre  = !re && !cs;
      ws_old  = m_ws;
      cnt_old = m_cnt;
      @(posedge xclk);
      m_ws = wq_pre && !m_wq_prev;  m_wq_prev = wq_pre;
      m_rs = rq_pre && !m_rq_prev;  m_rq_prev = rq_pre;
      m_oe = rq_pre;
      if (rq_pre) m_rd = ref_pick(cnt_old);
      if (!re && !we && !cs) m_conf = 1'b1;
      m_wlow = we ? 0 : m_wlow + 1;
`ifdef BUS_COLLISION_CNT_EN
      if (ws_old && ab == 8'hFF) m_cnt = '0;
      else if (rq_pre && $countones(ch_avail) > 1 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`else
      if (ws_old && cnt_old != m_cnt) m_cnt = cnt_old;
`endif
      #1;
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cs = 1; re = 1; we = 1; ab = '0; ch_data = '0; ch_avail = '0; tb_oe = 0; tb_val = '0;
      cs_b = 1; re_b = 1; we_b = 1; ab_b = '0; ch_data_b = '0; ch_avail_b = '0;
      tb_oe_b = 0; tb_val_b = '0;
      reset = 0;
      model_reset();
      #12;
      check_all();
      chk("rst_db_hiz", 32'(db), 32'h0000_FFFF);
      chk("rst_b_db_hiz", 32'(db_b), 32'h0000_00FF);
      @(negedge xclk); reset = 1;
      step(); step();

      // Write timing, WE_DLY=2
      cs = 0; we = 0; ab = 8'h10; tb_oe = 1; tb_val = 16'hA5C3;
      step(); chk("wr_e1_wq", 32'(write_qualified), 32'd0);
      step(); chk("wr_e2_wq", 32'(write_qualified), 32'd1);
      step(); chk("wr_e3_ws", 32'(write_strobe), 32'd1);
      step(); chk("wr_e4_ws", 32'(write_strobe), 32'd0);
      step(); chk("wr_db_in", 32'(db_in), 32'h0000_A5C3);
      we = 1; step(); chk("wr_drop_wq", 32'(write_qualified), 32'd0);
      cs = 1; tb_oe = 0; step();

      // cs dropping mid-write clears the qualifier at once; we_del is kept
      cs = 0; we = 0; tb_oe = 1; tb_val = 16'h0F0F;
      step(); step();
      cs = 1; #1; chk("cs_drop_wq", 32'(write_qualified), 32'd0);
      step();
      cs = 0; #1; chk("cs_back_wq", 32'(write_qualified), 32'd1);
      step(); step();
      we = 1; step(); cs = 1; tb_oe = 0; step();

      // Read priority
      for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = 16'($urandom);
      ch_data[2*DW +: DW] = 16'h1234; ch_data[5*DW +: DW] = 16'hBEEF;
      ch_avail = 8'b0010_0100; ab = 8'h20;
      cs = 0; re = 0; #1;
      chk("rd_pre_hiz", 32'(db), 32'h0000_FFFF);
      step(); chk("rd_e1_db", 32'(db), 32'h0000_1234);
      chk("rd_e1_rs", 32'(read_strobe), 32'd1);
      step(); chk("rd_e2_rs", 32'(read_strobe), 32'd0);
      step(); step(); chk("rd_e4_db", 32'(db), 32'h0000_1234);
      re = 1; step(); chk("rd_end_hiz", 32'(db), 32'h0000_FFFF);
      cs = 1; step();

      // Idle read
      ch_avail = '0; ab = 8'h40; cs = 0; re = 0;
      step(); chk("idle_db", 32'(db), 32'h0000_3333);
      re = 1; cs = 1; step(); step();

      // Parametrised instance: DW=8, NCH=3, WE_DLY=3
      cs_b = 0; we_b = 0; tb_oe_b = 1; tb_val_b = 8'h5A;
      step(); chk("b_e1_wq", 32'(wq_b), 32'd0);
      step(); chk("b_e2_wq", 32'(wq_b), 32'd0);
      step(); chk("b_e3_wq", 32'(wq_b), 32'd1); chk("b_e3_ws", 32'(ws_b), 32'd0);
      step(); chk("b_e4_ws", 32'(ws_b), 32'd1); chk("b_db_in", 32'(db_in_b), 32'h5A);
      we_b = 1; step(); cs_b = 1; tb_oe_b = 0; step();
      ch_data_b = {8'h11, 8'h7E, 8'h22}; ch_avail_b = 3'b110;
      cs_b = 0; re_b = 0;
      step(); chk("b_rd_db", 32'(db_b), 32'h7E); chk("b_rd_rs", 32'(rs_b), 32'd1);
      chk("b_rd_rq", 32'(rq_b), 32'd1);
      ch_avail_b = '0; step(); chk("b_idle_db", 32'(db_b), 32'h33);
      re_b = 1; step(); chk("b_end_hiz", 32'(db_b), 32'hFF);
      chk("b_conf", 32'(conf_b), 32'd0);
      cs_b = 1; step();

      // Conflict, then reset in the middle of a read
      ab = 8'h30; cs = 0; re = 0; we = 0;
      step(); chk("conf_set", 32'(rw_conflict), 32'd1);
      we = 1; step(); step(); chk("conf_sticky", 32'(rw_conflict), 32'd1);
      #2; reset = 0; model_reset(); #1;
      chk("rst_mid_hiz", 32'(db), 32'h0000_FFFF);
      chk("rst_mid_conf", 32'(rw_conflict), 32'd0);
      check_all();
      @(negedge xclk); reset = 1;
      step(); chk("no_rs_after_rst", 32'(read_strobe), 32'd0);
      step();
      re = 1; cs = 1; step(); step();

`ifdef BUS_COLLISION_CNT_EN
      // Collision counter
      ch_avail = 8'b0000_0011; ab = 8'h10; cs = 0; re = 0;
      step(); step(); step();
      re = 1; cs = 1; ch_avail = '0; step();
      ab = 8'hFF; cs = 0; re = 0;
      step(); chk("cnt_read", 32'(db), 32'h0000_0003);
      re = 1; cs = 1; step();
      cs = 0; we = 0; tb_oe = 1; tb_val = 16'h0000;
      step(); step(); step(); step();
      we = 1; step(); cs = 1; tb_oe = 0; step();
      cs = 0; re = 0;
      step(); chk("cnt_cleared", 32'(db), 32'h0000_0000);
      re = 1; cs = 1; step();
`endif

      // Random transactions, one idle cycle between accesses
      for (int t = 0; t < 60; t++) begin
         int kind, len;
         kind = $urandom_range(0, 2);
         len  = $urandom_range(1, 5);
         ab   = 8'($urandom);
         for (int c = 0; c < len; c++) begin
            if (kind == 0) begin
               cs = 0; re = 0; we = 1; tb_oe = 0;
               ch_avail = 8'($urandom);
               for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = 16'($urandom);
            end else if (kind == 1) begin
               cs = 0; re = 1; we = 0; tb_oe = 1; tb_val = 16'($urandom);
            end else begin
               cs = 1; re = 1; we = 1; tb_oe = 0;
            end
            step();
         end
         cs = 1; re = 1; we = 1; tb_oe = 0;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
